// File: rtl/interp_fir.sv
// ----------------------------------------------------------------------------
// interp_fir -- polyphase interpolating FIR for the QAM transmit path.
//
// Each accepted symbol-rate sample yields L filtered output samples. The
// result equals zero-stuff upsampling by L followed by a TAPS-tap FIR. Each
// output phase p is computed directly from a K = TAPS/L sample delay line as
//   y = sum_{k=0..K-1} h[k*L+p] * x[k]
// The coefficients can be loaded at runtime through a write port.
//
// Parameters
//   DW     input sample width (signed)
//   CW     coefficient width (signed)
//   L      interpolation factor (>= 2)
//   TAPS   total taps, a multiple of L
//   OW     output width (signed); must be narrower than the accumulator
//   OSHIFT arithmetic right shift applied before output narrowing
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_data/in_valid/in_ready  symbol-rate input stream (valid/ready)
//   out_data/out_valid/out_ready
//                              interpolated output stream (valid/ready)
//   coeff_we/coeff_addr/coeff_data
//                              coefficient write port; writes to addresses
//                              >= TAPS are ignored
//
// Configuration macro
//   INTERP_FIR_SAT_EN  defined:   the shifted accumulator saturates to the
//                                 OW-bit signed range
//                      undefined: the low OW bits are kept (two's-complement
//                                 wrap)
// ----------------------------------------------------------------------------
module interp_fir #(
  parameter int DW     = 4,
  parameter int CW     = 8,
  parameter int L      = 4,
  parameter int TAPS   = 72,
  parameter int OW     = 12,
  parameter int OSHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DW-1:0]           in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OW-1:0]           out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    coeff_we,
  input  logic [$clog2(TAPS)-1:0] coeff_addr,
  input  logic [CW-1:0]           coeff_data
);

  localparam int K   = TAPS / L;
  localparam int PW  = DW + CW;
  localparam int AW  = PW + $clog2(K);
  localparam int PHW = $clog2(L);
  localparam int ADW = $clog2(TAPS);

  typedef enum logic {IDLE, RUN} state_t;

  // Delay line, x[0] is the newest sample.
  logic signed [DW-1:0] r_x [K];
  // Coefficients are stored as [k][p] so that h[k*L+p] = r_h[k][p]. Each phase
  // then reads a single column, which keeps the per-tap mux small.
  logic signed [CW-1:0] r_h [K][L];

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PHW-1:0]  r_phase;
  logic [PHW-1:0]  w_phase_nxt;
  logic [OW-1:0]   r_out_data;
  logic            r_out_valid;

  logic            w_adv;
  logic            w_last;
  logic            w_accept;
  logic            w_load;
  logic            w_clear;
  logic signed [AW-1:0] w_acc;
  logic signed [AW-1:0] w_shift;
  logic [OW-1:0]   w_narrow;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  // The output register may advance when it is empty or being drained.
  assign w_adv    = !r_out_valid || out_ready;
  assign w_last   = (r_phase == PHW'(L - 1));
  // A new sample is taken only when the delay line is free: either idle, or
  // on the edge that emits the last phase of the current sample.
  assign in_ready = w_adv && ((r_state == IDLE) || ((r_state == RUN) && w_last));
  assign w_accept = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Phase MAC. This reads the delay line as registered, so an output loaded on
  // the same edge as an input shift still uses the pre-shift samples. It
  // likewise uses the old coefficient on a same-edge write.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written in always_comb gets a value before any
    // conditional or loop. Otherwise synthesis infers a latch.
    w_acc = '0;
    for (int k = 0; k < K; k++) begin
      w_acc = w_acc + AW'(PW'(r_h[k][r_phase]) * PW'(r_x[k]));
    end
  end

  // Floor division by 2^OSHIFT on a signed value.
  assign w_shift = w_acc >>> OSHIFT;

`ifdef INTERP_FIR_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  always_comb begin
    if (w_shift > SAT_MAX) begin
      w_narrow = SAT_MAX[OW-1:0];
    end else if (w_shift < SAT_MIN) begin
      w_narrow = SAT_MIN[OW-1:0];
    end else begin
      w_narrow = w_shift[OW-1:0];
    end
  end
`else
  // Plain two's-complement wrap. The bits above OW are intentionally dropped.
  logic w_unused_hi;
  assign w_unused_hi = ^w_shift[AW-1:OW];
  assign w_narrow    = w_shift[OW-1:0];
`endif

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        // The output register drains while idle.
        w_clear = w_adv;
        if (w_accept) begin
          w_state_nxt = RUN;
          w_phase_nxt = '0;
        end
      end
      RUN: begin
        // Backpressure (w_adv low) freezes the phase, so no phase is skipped.
        if (w_adv) begin
          w_load = 1'b1;
          if (!w_last) begin
            w_phase_nxt = r_phase + PHW'(1);
          end else if (w_accept) begin
            w_phase_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
            w_phase_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_phase_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples pre-edge values, whatever the order of the blocks.
    if (!rst_n) begin
      r_state <= IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_narrow;
      r_out_valid <= 1'b1;
    end else if (w_clear) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

  // --------------------------------------------------------------------------
  // Delay line
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < K; k++) begin
        r_x[k] <= '0;
      end
    end else if (w_accept) begin
      r_x[0] <= in_data;
      for (int k = 1; k < K; k++) begin
        r_x[k] <= r_x[k-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Coefficient storage
  // --------------------------------------------------------------------------
  // Each coefficient compares against its own address. An address of TAPS or
  // more matches no entry, so it is ignored without a separate range check.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this storage is deliberately reset. After reset the filter must
    // output zeros until coefficients are reloaded, so it is built from
    // flops rather than a RAM macro.
    if (!rst_n) begin
      for (int k = 0; k < K; k++) begin
        for (int p = 0; p < L; p++) begin
          r_h[k][p] <= '0;
        end
      end
    end else if (coeff_we) begin
      for (int k = 0; k < K; k++) begin
        for (int p = 0; p < L; p++) begin
          if (coeff_addr == ADW'(k * L + p)) begin
            r_h[k][p] <= coeff_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_interp_fir.sv
// ----------------------------------------------------------------------------
// tb_interp_fir -- directed self-checking bench for interp_fir (defaults:
// DW=4, CW=8, L=4, TAPS=72, OW=12, OSHIFT=0). Expected values are hand
// derived. With h[i]=i+1 the phase-p tap sum is sum_k (4k+p+1) = 630+18p.
// ----------------------------------------------------------------------------
module tb_interp_fir;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [11:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       coeff_we;
  logic [6:0] coeff_addr;
  logic [7:0] coeff_data;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

`ifdef INTERP_FIR_SAT_EN
  localparam int EXP_SAT = -2048;
`else
  localparam int EXP_SAT = -1904;
`endif

  interp_fir dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .coeff_we   (coeff_we),
    .coeff_addr (coeff_addr),
    .coeff_data (coeff_data)
  );

  always #5 clk = ~clk;

  // Inputs are driven, and outputs sampled, 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: h[i] = i+1, mode 1: h[i] = 127
  task automatic load_coeffs(input int mode);
    for (int i = 0; i < 72; i++) begin
      coeff_we   = 1'b1;
      coeff_addr = 7'(i);
      coeff_data = (mode == 0) ? 8'(i + 1) : 8'd127;
      tick();
    end
    coeff_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    coeff_we   = 1'b0;
    coeff_addr = '0;
    coeff_data = '0;
    #12;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_data", $signed(out_data), 0);
    check("reset_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;

    // ---------------- impulse response ----------------
    load_coeffs(0);
    begin : impulse
      int   n_out;
      int   n_sent;
      logic acc;
      n_out = 0; n_sent = 0;
      in_valid = 1'b1; in_data = 4'd1;
      for (int cyc = 0; cyc < 200 && n_out < 80; cyc++) begin
        acc = in_valid && in_ready;
        tick();
        if (acc) begin
          n_sent++;
          in_data  = '0;
          in_valid = (n_sent < 20);
        end
        if (out_valid) begin
          check($sformatf("impulse[%0d]", n_out), $signed(out_data),
                (n_out < 72) ? n_out + 1 : 0);
          n_out++;
        end
      end
      check("impulse_count", n_out, 80);
    end
    in_valid = 1'b0;
    tick(); tick();
    check("idle_out_valid", 32'(out_valid), 0);
    check("idle_in_ready", 32'(in_ready), 1);

    // ---------------- streaming: 40 samples of +1 ----------------
    begin : stream
      int   n_acc, n_out, first, last, gaps, prev_acc;
      logic acc;
      logic signed [31:0] last_val;
      n_acc = 0; n_out = 0; first = -1; last = -1; gaps = 0; prev_acc = -1;
      last_val = '0;
      in_valid = 1'b1; in_data = 4'd1;
      for (int cyc = 0; cyc < 300; cyc++) begin
        acc = in_valid && in_ready;
        if (acc) begin
          if (prev_acc >= 0 && cyc - prev_acc != 4) gaps++;
          prev_acc = cyc;
          n_acc++;
        end
        tick();
        if (acc && n_acc == 40) in_valid = 1'b0;
        if (out_valid) begin
          if (first < 0) first = cyc;
          last = cyc;
          n_out++;
          last_val = $signed(out_data);
        end
      end
      check("stream_accepts", n_acc, 40);
      check("stream_outputs", n_out, 160);
      check("stream_contiguous", last - first + 1, 160);
      check("stream_ready_spacing", gaps, 0);
      check("stream_last_value", last_val, 684);
    end

    // ---------------- backpressure ----------------
    // Delay line is all ones. Sample 2 gives 630+18p+(p+1). Then sample 3
    // gives phase 0 = 637.
    in_valid = 1'b1; in_data = 4'd2;
    tick();
    in_valid = 1'b0;
    tick(); check("bp_ph0", $signed(out_data), 631);
    tick(); check("bp_ph1", $signed(out_data), 650);
    tick(); check("bp_ph2", $signed(out_data), 669);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_data[%0d]", i), $signed(out_data), 669);
      check($sformatf("bp_hold_valid[%0d]", i), 32'(out_valid), 1);
      check($sformatf("bp_hold_in_ready[%0d]", i), 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick(); check("bp_ph3", $signed(out_data), 688);
    in_valid = 1'b0;
    tick(); check("bp_next_ph0", $signed(out_data), 637);
    tick(); tick(); tick(); tick();
    check("bp_idle", 32'(out_valid), 0);

    // ---------------- coefficient writes ----------------
    coeff_we = 1'b1; coeff_addr = 7'd100; coeff_data = 8'd55;
    tick();
    coeff_we = 1'b0;
    // Line becomes [0,3,2,1...]: 5*3 + 9*2 + (630-15) = 648.
    in_valid = 1'b1; in_data = 4'd0;
    tick();
    in_valid = 1'b0;
    tick(); check("bad_addr_ignored", $signed(out_data), 648);
    tick(); tick(); tick(); tick();
    // Line becomes [1,0,3,2,1...]. The h[0] write shares the edge that loads
    // phase 0, so the old h[0]=1 applies: 1 + 27 + 26 + 602 = 656.
    in_valid = 1'b1; in_data = 4'd1;
    tick();
    in_valid = 1'b0;
    coeff_we = 1'b1; coeff_addr = 7'd0; coeff_data = 8'd10;
    tick(); check("coef_same_edge_old", $signed(out_data), 656);
    coeff_we = 1'b0;
    in_valid = 1'b1; in_data = 4'd1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    // Line becomes [1,1,0,3,2,1...] with h[0]=10: 10 + 5 + 39 + 34 + 585 = 673.
    tick(); check("coef_new_value", $signed(out_data), 673);
    tick(); tick(); tick(); tick();

    // ---------------- saturation / wrap ----------------
    load_coeffs(1);
    begin : sat
      int   n_acc;
      logic acc;
      logic signed [31:0] last_val;
      n_acc = 0; last_val = '0;
      in_valid = 1'b1; in_data = 4'b1000;
      for (int cyc = 0; cyc < 200; cyc++) begin
        acc = in_valid && in_ready;
        if (acc) n_acc++;
        tick();
        if (acc && n_acc == 20) in_valid = 1'b0;
        if (out_valid) last_val = $signed(out_data);
      end
      check("sat_accepts", n_acc, 20);
      check("sat_steady", last_val, EXP_SAT);
    end

    // ---------------- reset mid-burst ----------------
    in_valid = 1'b1; in_data = 4'd1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("pre_reset_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", $signed(out_data), 0);
    #2 rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = 4'd1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst_imp_valid[%0d]", i), 32'(out_valid), 1);
      check($sformatf("rst_imp_data[%0d]", i), $signed(out_data), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/interp_fir.md
# interp_fir

Parametrised polyphase interpolating FIR for the QAM transmit DSP path. It accepts one signed symbol-rate sample per handshake and emits L filtered output samples per input, which is equivalent to zero-stuff upsampling by L followed by a TAPS-tap FIR. Coefficients are runtime-loadable through a write port. It sits between the QAM symbol mapper and the DAC/NCO stage, and provides full valid/ready flow control on both sides.

## Interface
- DW, 4: input sample width, signed.
- CW, 8: coefficient width, signed.
- L, 4: interpolation factor, ≥2.
- TAPS, 72: total filter taps; must be a multiple of L. K = TAPS/L taps per phase.
- OW, 12: output width, signed.
- OSHIFT, 0: arithmetic right shift applied to the accumulator before output narrowing.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DW  signed input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  OW  signed filtered sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- coeff_we  in  1  coefficient write strobe.
- coeff_addr  in  $clog2(TAPS)  tap index h[addr], unsigned.
- coeff_data  in  CW  signed coefficient value.

## Operation
- Storage:
  - Delay line x[0..K-1], where x[0] is the newest sample.
  - Coefficient registers h[0..TAPS-1].
  - Phase counter p, range 0..L-1.
  - FSM with states IDLE and RUN.
- Phase-p output: y = Σ_{k=0..K-1} h[k·L+p]·x[k], computed in full precision.
  - Product width is DW+CW.
  - Accumulator width AW = DW+CW+$clog2(K).
  - The accumulator is shifted arithmetically right by OSHIFT (floor), then narrowed to OW as set by the configuration macro.
- adv = !out_valid || out_ready.
  - The output register loads only when adv is high.
  - While adv is low, out_data and out_valid hold.
- in_ready = adv && (state==IDLE || (state==RUN && p==L-1)). The signal is combinational.
- Input accept (in_valid && in_ready):
  - The delay line shifts and x[0] takes in_data.
  - p is set to 0 and the FSM goes to RUN.
- RUN with adv high:
  - The output register takes y for phase p, computed from the delay line as it stood before any same-edge shift.
  - out_valid is set to 1.
  - If p<L-1, p increments.
  - If p==L-1 with no input accept, the FSM goes to IDLE.
  - If p==L-1 with an accept, p goes to 0 and the FSM stays in RUN.
- IDLE with adv high: out_valid is cleared to 0.
- Coefficient write:
  - On coeff_we, h[coeff_addr] takes coeff_data at the edge.
  - Writes with coeff_addr ≥ TAPS are ignored.
  - Writes are allowed mid-stream. A write takes effect for outputs computed on later edges and never corrupts the handshake.
- Reset (async, any time including mid-burst):
  - FSM goes to IDLE and p to 0.
  - Delay line and h are cleared to 0.
  - out_valid=0, out_data=0.
  - in_ready is 1 once the FSM is in IDLE.

## Timing
- Latency: an accept on edge n presents phase 0 on out_data after edge n+1. Phase p follows at edge n+1+p when there is no backpressure.
- Sustained throughput with in_valid=1 and out_ready=1: one output per cycle. in_ready pulses high one cycle in every L, and out_valid stays continuously high after the first output.
- Backpressure stalls the phase counter. No sample is dropped or duplicated.
- A coefficient write and an output load on the same edge: the output uses the old coefficient.

## Configuration
- INTERP_FIR_SAT_EN:
  - Defined: the shifted accumulator saturates to [−2^(OW−1), 2^(OW−1)−1].
  - Undefined: out_data is the low OW bits of the shifted accumulator (two's-complement wrap). No saturation logic is built.

## Test plan
- **Impulse response.** Defaults, OSHIFT=0. Load h[i]=i+1 for i=0..71, then send 1 followed by 17 zeros with out_ready=1. Required: outputs are 1,2,…,72 in order, and later outputs are 0.
- **Saturation.** Load all h=127 and stream a constant −8 for 18+ samples.
  - With INTERP_FIR_SAT_EN: steady out_data is −2048.
  - Without it: steady out_data is −1904 (−18288 wrapped to 12 bits).
- **Backpressure.** Drop out_ready for 5 cycles at phase 2 of a burst. Required: out_data and out_valid hold, in_ready=0, and resuming yields phases 2,3 and then the next sample with no loss.
- **Streaming.** Hold in_valid=1 and out_ready=1 for 40 samples. Required: 160 outputs in 160 consecutive cycles, with in_ready high exactly every 4th cycle.
- **Coefficient writes.** A write with addr=100 leaves all h unchanged. A write to h[0] during a burst changes only outputs loaded after the write edge.
- **Reset mid-burst.** Assert rst_n low at phase 2. Required: out_valid=0 and out_data=0 immediately. After release, in_ready=1, and an impulse produces all-zero outputs until coefficients are reloaded.
